// File: rtl/burst_mem_responder.sv
// Burst memory endpoint: 4-beat x 64-bit write bursts into 256-bit lines,
// reads queued and returned as 4 back-to-back beats after a fixed latency.
module burst_mem_responder #(
    parameter int MEM_LINES    = 256,
    parameter int READ_LATENCY = 4,
    parameter int QDEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid,
    output logic [31:0] bmem_raddr,
    output logic        bmem_err
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int QW    = $clog2(QDEPTH);
    localparam int CW    = $clog2(READ_LATENCY + 1);
    // The push edge itself already counts as one elapsed latency cycle.
    localparam logic [CW-1:0] CD_PUSH = CW'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);
    localparam logic [QW:0]   Q_FULL  = (QW + 1)'(QDEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [63:0] mem [MEM_LINES*4];

    logic [1:0]       wcnt_reg;
    logic [IDX_W-1:0] wline_reg;
    logic [IDX_W-1:0] wr_line;
    logic             err_reg;

    logic [31:0]      q_addr [QDEPTH];
    logic [CW-1:0]    q_cd   [QDEPTH];
    logic [QW-1:0]    head_reg;
    logic [QW-1:0]    tail_reg;
    logic [QW:0]      count_reg;

    logic [0:0]       state_reg;
    logic [1:0]       rcnt_reg;
    logic [31:0]      raddr_reg;

    logic        burst_free;
    logic        head_elig;
    logic        pop;
    logic        q_full;
    logic        accept;
    logic        bypass;
    logic        push;
    logic        start;
    logic        err_next;
    logic [31:0] req_addr;
    logic [31:0] start_addr;

    assign req_addr   = bmem_addr & 32'hFFFF_FFE0;
    assign wr_line    = (wcnt_reg == 2'd0) ? bmem_addr[5 +: IDX_W] : wline_reg;

    assign burst_free = (state_reg == ST_IDLE) || (rcnt_reg == 2'd3);
    assign head_elig  = (count_reg != '0) && (q_cd[head_reg] == '0);
    assign pop        = burst_free && head_elig;
    assign q_full     = (count_reg == Q_FULL) && !pop;
    assign accept     = bmem_read && !bmem_write && (wcnt_reg == 2'd0) && !q_full;
    // With a one-cycle latency an empty queue hands the request straight to the FSM.
    assign bypass     = (READ_LATENCY == 1) && accept && (count_reg == '0) && burst_free;
    assign push       = accept && !bypass;
    assign start      = pop || bypass;
    assign start_addr = pop ? q_addr[head_reg] : req_addr;
    assign err_next   = err_reg || (bmem_read && !accept) || (!bmem_write && (wcnt_reg != 2'd0));

    always_ff @(posedge clk) begin
        if (rst_n && bmem_write) begin
            mem[{wr_line, wcnt_reg}] <= bmem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_reg  <= 2'd0;
            wline_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= err_next;
            if (bmem_write) begin
                wcnt_reg  <= wcnt_reg + 2'd1;
                wline_reg <= wr_line;
            end else begin
                wcnt_reg  <= 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_addr[i] <= '0;
                q_cd[i]   <= '0;
            end
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (push && (tail_reg == QW'(i))) begin
                    q_addr[i] <= req_addr;
                    q_cd[i]   <= CD_PUSH;
                end else if (q_cd[i] != '0) begin
                    q_cd[i]   <= q_cd[i] - 1'b1;
                end
            end
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push && pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            rcnt_reg  <= 2'd0;
            raddr_reg <= '0;
        end else if (start) begin
            state_reg <= ST_BURST;
            rcnt_reg  <= 2'd0;
            raddr_reg <= start_addr;
        end else if (state_reg == ST_BURST) begin
            rcnt_reg <= rcnt_reg + 2'd1;
            if (rcnt_reg == 2'd3) begin
                state_reg <= ST_IDLE;
            end
        end
    end

    // Beats read the array live so they see every write committed on earlier edges.
    assign bmem_rvalid = (state_reg == ST_BURST);
    assign bmem_rdata  = bmem_rvalid ? mem[{raddr_reg[5 +: IDX_W], rcnt_reg}] : 64'd0;
    assign bmem_raddr  = raddr_reg;
    assign bmem_err    = err_reg;

endmodule
